// File: rtl/motion_bbox_overlay.sv
// rtl/motion_bbox_overlay.sv - per-frame motion bounding box extractor with RGB565 rectangle overlay
// Optional build macro BBOX_DOUBLE_BORDER_EN draws a 2-pixel border inward instead of 1 pixel.
module motion_bbox_overlay #(
    parameter int          IMG_HDISP  = 640,
    parameter int          IMG_VDISP  = 480,
    parameter logic [18:0] MIN_PIXELS = 19'd16,
    parameter logic [15:0] BOX_COLOR  = 16'hF800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [15:0] per_img_data,
    input  logic        per_img_bit,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [15:0] post_img_data,
    output logic [9:0]  box_left,
    output logic [9:0]  box_right,
    output logic [9:0]  box_top,
    output logic [9:0]  box_bottom,
    output logic        box_valid,
    output logic        frame_done
);
    localparam logic [9:0] X_MAX = 10'(IMG_HDISP - 1);
    localparam logic [9:0] Y_MAX = 10'(IMG_VDISP - 1);

    logic        vs_d, href_d, armed, x_over, x_over_nxt;
    logic [9:0]  x, y, x_nxt, y_nxt, cur_x, cur_y;
    logic [9:0]  min_x, max_x, min_y, max_y;
    logic [9:0]  min_x_nxt, max_x_nxt, min_y_nxt, max_y_nxt;
    logic [18:0] cnt, cnt_nxt;
    logic        frame_start, frame_end, href_fall, pix_ok, in_range, hit;
    logic        x_edge, y_edge, x_in, y_in, border;

    assign frame_start = per_frame_vsync & ~vs_d;
    assign frame_end   = ~per_frame_vsync & vs_d;
    assign href_fall   = href_d & ~per_frame_href;
    assign pix_ok      = armed & per_frame_vsync & per_frame_href & per_frame_clken;
    // x_over marks that the last in-range column has been consumed on this line
    assign in_range    = frame_start | ~x_over;
    assign hit         = pix_ok & in_range & per_img_bit;
    assign cur_x       = frame_start ? 10'd0 : x;
    assign cur_y       = frame_start ? 10'd0 : y;

    always_comb begin
        x_nxt      = cur_x;
        y_nxt      = cur_y;
        x_over_nxt = frame_start ? 1'b0 : x_over;
        if (pix_ok) begin
            if (cur_x == X_MAX) x_over_nxt = 1'b1;
            else                x_nxt      = cur_x + 10'd1;
        end
        if (href_fall) begin
            x_nxt      = 10'd0;
            x_over_nxt = 1'b0;
            if (cur_y != Y_MAX) y_nxt = cur_y + 10'd1;
        end
    end

    always_comb begin
        min_x_nxt = frame_start ? X_MAX : min_x;
        max_x_nxt = frame_start ? 10'd0 : max_x;
        min_y_nxt = frame_start ? Y_MAX : min_y;
        max_y_nxt = frame_start ? 10'd0 : max_y;
        cnt_nxt   = frame_start ? 19'd0 : cnt;
        if (hit) begin
            if (cur_x < min_x_nxt) min_x_nxt = cur_x;
            if (cur_x > max_x_nxt) max_x_nxt = cur_x;
            if (cur_y < min_y_nxt) min_y_nxt = cur_y;
            if (cur_y > max_y_nxt) max_y_nxt = cur_y;
            if (cnt_nxt != '1)     cnt_nxt   = cnt_nxt + 19'd1;
        end
    end

`ifdef BBOX_DOUBLE_BORDER_EN
    assign x_edge = (cur_x == box_left) || (cur_x == box_right) ||
                    (cur_x == box_left + 10'd1) || (cur_x == box_right - 10'd1);
    assign y_edge = (cur_y == box_top) || (cur_y == box_bottom) ||
                    (cur_y == box_top + 10'd1) || (cur_y == box_bottom - 10'd1);
`else
    assign x_edge = (cur_x == box_left) || (cur_x == box_right);
    assign y_edge = (cur_y == box_top) || (cur_y == box_bottom);
`endif
    assign x_in   = (cur_x >= box_left) && (cur_x <= box_right);
    assign y_in   = (cur_y >= box_top) && (cur_y <= box_bottom);
    assign border = box_valid & pix_ok & in_range & ((x_edge & y_in) | (y_edge & x_in));

    // vs_d resets high so a frame already in progress at reset release never looks like a start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d             <= 1'b1;
            href_d           <= 1'b0;
            armed            <= 1'b0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_data    <= 16'd0;
        end else begin
            vs_d             <= per_frame_vsync;
            href_d           <= per_frame_href;
            if (frame_start) armed <= 1'b1;
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_frame_clken <= per_frame_clken;
            post_img_data    <= border ? BOX_COLOR : per_img_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= 10'd0;
            y      <= 10'd0;
            x_over <= 1'b0;
            min_x  <= 10'd0;
            max_x  <= 10'd0;
            min_y  <= 10'd0;
            max_y  <= 10'd0;
            cnt    <= 19'd0;
        end else begin
            x      <= x_nxt;
            y      <= y_nxt;
            x_over <= x_over_nxt;
            min_x  <= min_x_nxt;
            max_x  <= max_x_nxt;
            min_y  <= min_y_nxt;
            max_y  <= max_y_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            box_valid  <= 1'b0;
            box_left   <= 10'd0;
            box_right  <= 10'd0;
            box_top    <= 10'd0;
            box_bottom <= 10'd0;
        end else begin
            frame_done <= frame_end & armed;
            if (frame_end && armed) begin
                if (cnt >= MIN_PIXELS) begin
                    box_left   <= min_x;
                    box_right  <= max_x;
                    box_top    <= min_y;
                    box_bottom <= max_y;
                    box_valid  <= 1'b1;
                end else begin
                    box_valid  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_motion_bbox_overlay.sv
// tb/tb_motion_bbox_overlay.sv - scoreboard bench for motion_bbox_overlay on a reduced 128x64 frame
module tb_motion_bbox_overlay;
    localparam int          H  = 128;
    localparam int          V  = 64;
    localparam logic [15:0] BC = 16'hF800;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        vsync = 1'b0, href = 1'b0, clken = 1'b0, img_bit = 1'b0;
    logic [15:0] img_data = 16'd0;
    logic        post_vsync, post_href, post_clken, box_valid, frame_done;
    logic [15:0] post_data;
    logic [9:0]  box_left, box_right, box_top, box_bottom;

    always #5 clk = ~clk;

    motion_bbox_overlay #(
        .IMG_HDISP(H), .IMG_VDISP(V), .MIN_PIXELS(19'd16), .BOX_COLOR(BC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
        .per_img_data(img_data), .per_img_bit(img_bit),
        .post_frame_vsync(post_vsync), .post_frame_href(post_href),
        .post_frame_clken(post_clken), .post_img_data(post_data),
        .box_left(box_left), .box_right(box_right), .box_top(box_top),
        .box_bottom(box_bottom), .box_valid(box_valid), .frame_done(frame_done)
    );

    int          n_vec = 0, n_err = 0, fd_count = 0, fd0 = 0;
    logic [18:0] sb_q[$];
    logic [18:0] sb_exp;
    bit          sb_en = 1'b0;
    bit          ov_valid = 1'b0;
    int          ov_l = 0, ov_r = 0, ov_t = 0, ov_b = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit on_border(input int px, input int py);
        bit xe, ye;
        xe = (px == ov_l) || (px == ov_r);
        ye = (py == ov_t) || (py == ov_b);
`ifdef BBOX_DOUBLE_BORDER_EN
        xe = xe || (px == ov_l + 1) || (px == ov_r - 1);
        ye = ye || (py == ov_t + 1) || (py == ov_b - 1);
`endif
        return (xe && py >= ov_t && py <= ov_b) || (ye && px >= ov_l && px <= ov_r);
    endfunction

    function automatic logic motion(input int kind, input int px, input int py);
        case (kind)
            1:       return (px >= 100 && px <= 119 && py >= 50 && py <= 59);
            2:       return (py == 5  && px >= 10  && px <= 24);
            3:       return (py == 63 && px >= 112 && px <= 127);
            4:       return (py == 20 && px >= 128 && px <= 159);
            default: return 1'b0;
        endcase
    endfunction

    // One clock: compare last cycle's output against the queue, then drive and enqueue the new expectation
    task automatic drive(input logic vs, input logic hr, input logic ce, input logic [15:0] d,
                         input logic b, input int px, input int py);
        logic [15:0] e;
        @(negedge clk);
        if (sb_q.size() > 0) begin
            sb_exp = sb_q.pop_front();
            check_val("post_out", {13'd0, post_vsync, post_href, post_clken, post_data}, {13'd0, sb_exp});
        end
        if (frame_done) fd_count++;
        #1;
        vsync = vs; href = hr; clken = ce; img_data = d; img_bit = b;
        e = (vs && hr && ce && ov_valid && px < H && on_border(px, py)) ? BC : d;
        if (sb_en) sb_q.push_back({vs, hr, ce, e});
    endtask

    task automatic do_reset(input logic vs);
        drive(vs, 1'b0, 1'b0, 16'($urandom), 1'b0, 0, 0);
        rst_n = 1'b0;
        sb_q.delete();
        sb_en = 1'b0;
        ov_valid = 1'b0;
        repeat (3) drive(vs, 1'b0, 1'b1, 16'($urandom), 1'b1, 0, 0);
        check_val("rst_post_data", 32'(post_data), 32'd0);
        check_val("rst_post_ctrl", {29'd0, post_vsync, post_href, post_clken}, 32'd0);
        check_val("rst_box_valid", 32'(box_valid), 32'd0);
        check_val("rst_frame_done", 32'(frame_done), 32'd0);
        check_val("rst_box", {2'd0, box_left, box_right, box_top[9:0]} | 32'(box_bottom), 32'd0);
        rst_n = 1'b1;
        sb_en = 1'b1;
    endtask

    task automatic run_frame(input int kind, input int rst_line);
        int          npix, px;
        logic        ce, b;
        logic [15:0] d;
        drive(1'b1, 1'b0, 1'b0, 16'($urandom), 1'b1, 0, 0);
        drive(1'b1, 1'b0, 1'b1, 16'($urandom), 1'b1, 0, 0);
        for (int yy = 0; yy < V; yy++) begin
            if (yy == rst_line) do_reset(1'b1);
            npix = (kind == 4 && yy == 20) ? 160 : H;
            px = 0;
            while (px < npix) begin
                ce = ($urandom_range(0, 7) != 0);
                d  = 16'($urandom);
                b  = ce ? motion(kind, px, yy) : 1'($urandom_range(0, 1));
                drive(1'b1, 1'b1, ce, d, b, px, yy);
                if (ce) px++;
            end
            repeat (3) drive(1'b1, 1'b0, 1'b1, 16'($urandom), 1'b1, 0, yy);
        end
        drive(1'b0, 1'b1, 1'b1, 16'($urandom), 1'b1, 0, 0);
        repeat (5) drive(1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0, 0, 0);
    endtask

    task automatic check_latch(input string tag, input int n_done, input logic v,
                               input int l, input int r, input int t, input int bt);
        check_val({tag, "_done_cnt"}, 32'(fd_count - fd0), 32'(n_done));
        check_val({tag, "_valid"},    32'(box_valid),      32'(v));
        check_val({tag, "_left"},     32'(box_left),       32'(l));
        check_val({tag, "_right"},    32'(box_right),      32'(r));
        check_val({tag, "_top"},      32'(box_top),        32'(t));
        check_val({tag, "_bottom"},   32'(box_bottom),     32'(bt));
    endtask

    task automatic set_ov(input bit v, input int l, input int r, input int t, input int bt);
        ov_valid = v; ov_l = l; ov_r = r; ov_t = t; ov_b = bt;
    endtask

    initial begin
        repeat (2) drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 0, 0);
        do_reset(1'b0);

        fd0 = fd_count; run_frame(1, -1);
        check_latch("f0", 1, 1'b1, 100, 119, 50, 59);
        set_ov(1'b1, 100, 119, 50, 59);

        fd0 = fd_count; run_frame(1, 20);
        check_latch("partial", 0, 1'b0, 0, 0, 0, 0);

        fd0 = fd_count; run_frame(1, -1);
        check_latch("f1", 1, 1'b1, 100, 119, 50, 59);
        set_ov(1'b1, 100, 119, 50, 59);

        fd0 = fd_count; run_frame(2, -1);
        check_latch("few", 1, 1'b0, 100, 119, 50, 59);
        set_ov(1'b0, 0, 0, 0, 0);

        fd0 = fd_count; run_frame(3, -1);
        check_latch("corner", 1, 1'b1, 112, 127, 63, 63);
        set_ov(1'b1, 112, 127, 63, 63);

        fd0 = fd_count; run_frame(4, -1);
        check_latch("excess", 1, 1'b0, 112, 127, 63, 63);

        drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
